// File: rtl/uart_rx.sv
// 8N1 serial receiver with a first-word-fall-through byte FIFO and one-cycle error pulses.
// Define UART_RX_PARITY_EN to expect an even-parity bit before the stop bit (8E1).
module uart_rx #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Rx_Serial,
  input  logic       rd_en,
  output logic [7:0] rx_data,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic [2:0] state_dbg
);
  // Read handshake: rx_empty low means rx_data is valid; rd_en is the ready,
  // and a byte is consumed only in a cycle where rd_en = 1 and rx_empty = 0.

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t state, state_next;
  logic          rx_meta, rxs;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tick, push, pop, frame_hit;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wptr, rptr;
`ifdef UART_RX_PARITY_EN
  logic          par_bad, par_hit;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= Rx_Serial;
      rxs     <= rx_meta;
    end
  end

  // Counter restarts on every state change, so the first compare lands mid-bit.
  assign tick = (state == S_START) ? (cnt == HALF_LAST) : (cnt == FULL_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (!rxs) state_next = S_START;
      S_START:  if (tick) state_next = rxs ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
      S_DATA:   if (tick && bit_idx == 3'd7) state_next = S_PARITY;
      S_PARITY: if (tick) state_next = S_STOP;
`else
      S_DATA:   if (tick && bit_idx == 3'd7) state_next = S_STOP;
`endif
      S_STOP:   if (tick) state_next = rxs ? S_IDLE : S_BREAK;
      S_BREAK:  if (rxs) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    push      = 1'b0;
    frame_hit = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_hit   = 1'b0;
`endif
    if (state == S_STOP && tick) begin
      if (!rxs) frame_hit = 1'b1;
`ifdef UART_RX_PARITY_EN
      else if (par_bad) par_hit = 1'b1;
`endif
      else push = 1'b1;
    end
  end

  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (state_next != state || tick || state == S_IDLE || state == S_BREAK) cnt <= '0;
      else cnt <= cnt + 1'b1;
      if (state == S_START && tick) bit_idx <= '0;
      else if (state == S_DATA && tick) begin
        bit_idx <= bit_idx + 3'd1;
        shreg   <= {rxs, shreg[7:1]};
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (state == S_START && tick) par_bad <= 1'b0;
      else if (state == S_PARITY && tick) par_bad <= ^{shreg, rxs};
      parity_err <= par_hit;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  // Pointers carry one extra wrap bit to tell full from empty.
  assign rx_empty = (wptr == rptr);
  assign rx_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop      = rd_en && !rx_empty;
  assign rx_data  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push && (!rx_full || pop)) begin
        mem[wptr[AW-1:0]] <= shreg;
        wptr <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      frame_err <= frame_hit;
      overrun   <= push && rx_full && !pop;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit with a 4-entry FIFO.
// Error pulses are counted on every falling edge and checked as per-scenario deltas.
module tb_uart_rx;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset, rx_pin, rd_en;
  logic [7:0] rx_data;
  logic       rx_empty, rx_full, frame_err, overrun, parity_err;
  logic [2:0] state_dbg;

  int total = 0;
  int bad = 0;
  int n_frame = 0;
  int n_over = 0;
  int n_par = 0;
  int f0, o0, p0;
  logic [7:0] exp_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .Rx_Serial(rx_pin), .rd_en(rd_en),
    .rx_data(rx_data), .rx_empty(rx_empty), .rx_full(rx_full),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) n_frame++;
    if (overrun === 1'b1) n_over++;
    if (parity_err === 1'b1) n_par++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx_pin = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic use_par, input logic par_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (use_par) drive_bit(par_bit);
    drive_bit(stop_bit);
  endtask

  task automatic pop_byte(input string tag);
    logic [7:0] exp;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_underflow"}, 32'd1, 32'd0);
      return;
    end
    exp = exp_q.pop_front();
    chk({tag, "_valid"}, rx_empty, 1'b0);
    chk(tag, rx_data, exp);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic snap();
    f0 = n_frame;
    o0 = n_over;
    p0 = n_par;
  endtask

  initial begin
    reset = 1'b1;
    rx_pin = 1'b1;
    rd_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_empty", rx_empty, 1'b1);
    chk("rst_full", rx_full, 1'b0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_state", state_dbg, 3'd0);
    chk("rst_pulses", {frame_err, overrun, parity_err}, 3'b000);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 0xA5: start seen 2 edges after the pin falls, stop sampled in cycle 152, byte visible in 153
    snap();
    fork
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      begin
        repeat (154) @(posedge clk);
        @(negedge clk);
        chk("a5_empty_at_stop_sample", rx_empty, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("a5_empty_after_stop", rx_empty, 1'b0);
      end
    join
    exp_q.push_back(8'hA5);
    pop_byte("a5_data");
    chk("a5_empty_after_pop", rx_empty, 1'b1);
    chk("a5_no_errors", (n_frame - f0) + (n_over - o0) + (n_par - p0), 0);

    // short low glitch is rejected at the start sample
    snap();
    rx_pin = 1'b0;
    repeat (5) @(negedge clk);
    rx_pin = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_state_idle", state_dbg, 3'd0);
    chk("glitch_empty", rx_empty, 1'b1);
    chk("glitch_no_errors", (n_frame - f0) + (n_over - o0) + (n_par - p0), 0);

    // 0x3C with a low stop bit held low: one frame error, then 0x55 gets through
    snap();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    chk("break_state", state_dbg, 3'd5);
    rx_pin = 1'b1;
    repeat (10) @(negedge clk);
    chk("frame_err_count", n_frame - f0, 1);
    chk("frame_empty", rx_empty, 1'b1);
    chk("frame_state_idle", state_dbg, 3'd0);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(8'h55);
    pop_byte("after_break_data");
    chk("after_break_errors", (n_frame - f0) + (n_over - o0), 1);

    // fill the FIFO and overrun on the fifth byte
    snap();
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 1'b0, 1'b0);
      if (i <= 4) exp_q.push_back(8'(i));
      if (i == 3) chk("not_full_at_3", rx_full, 1'b0);
      if (i == 4) chk("full_at_4", rx_full, 1'b1);
    end
    chk("overrun_count", n_over - o0, 1);
    chk("full_after_overrun", rx_full, 1'b1);
    for (int i = 0; i < 4; i++) pop_byte("fifo_order");
    chk("fifo_drained_empty", rx_empty, 1'b1);
    chk("fifo_drained_full", rx_full, 1'b0);
    chk("fifo_frame_errs", n_frame - f0, 0);

    // reset in the middle of data bit 3 of 0xF0, then 0x0F
    snap();
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    rx_pin = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_reset_state_data", state_dbg, 3'd2);
    reset = 1'b1;
    #1;
    chk("midbyte_reset_state", state_dbg, 3'd0);
    chk("midbyte_reset_empty", rx_empty, 1'b1);
    rx_pin = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(8'h0F);
    pop_byte("after_reset_data");
    chk("after_reset_empty", rx_empty, 1'b1);
    chk("after_reset_errors", (n_frame - f0) + (n_over - o0) + (n_par - p0), 0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: parity 1 is good, parity 0 is a mismatch
    snap();
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    exp_q.push_back(8'h07);
    pop_byte("parity_good_data");
    chk("parity_good_no_err", n_par - p0, 0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("parity_bad_count", n_par - p0, 1);
    chk("parity_bad_discard", rx_empty, 1'b1);
`else
    chk("parity_err_never", n_par, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver that decodes the 8N1 byte stream arriving on the board `Rx_Serial` pin and queues received bytes for the bus-side peripheral logic. It is the receive end of the link whose transmit end drives `Tx_Serial`, running at 9600 baud from the 100 MHz system clock. It includes a small first-word-fall-through FIFO, and reports framing and overrun errors as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, 10417: system clocks per bit (100 MHz / 9600); must be ≥ 4.
- `FIFO_DEPTH`, 4: receive FIFO entries; power of two, ≥ 2.

- `clk` input 1: system clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `Rx_Serial` input 1: serial line; idles high; asynchronous to `clk`.
- `rd_en` input 1: pops the FIFO head when `rx_empty` = 0; ignored when empty.
- `rx_data` output 8: FIFO head byte; valid while `rx_empty` = 0.
- `rx_empty` output 1: FIFO empty.
- `rx_full` output 1: FIFO full.
- `frame_err` output 1: one-cycle pulse when a stop bit is sampled low.
- `overrun` output 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `parity_err` output 1: one-cycle pulse on a parity mismatch; tied 0 when parity is compiled out.

## Operation
- `Rx_Serial` passes through a 2-FF synchronizer whose flops reset to 1. All decoding uses the synchronized value `rxs`.
- State machine: IDLE, START, DATA, PARITY (only with the macro), STOP, BREAK.
- IDLE: on `rxs` = 0, clear the counter and go to START.
- START: when the counter reaches `CLKS_PER_BIT/2` (integer division), sample `rxs`.
  - 0: clear the counter and bit index, go to DATA.
  - 1: treat as a glitch and return to IDLE; nothing is reported.
- DATA: sample every `CLKS_PER_BIT` cycles. Shift LSB first; bit 0 is the first data bit. After 8 bits go to PARITY or STOP.
- PARITY: sample one bit at `CLKS_PER_BIT`. Even parity: the XOR of the 8 data bits and the parity bit must be 0. A mismatch sets an internal flag.
- STOP: sample at `CLKS_PER_BIT`.
  - `rxs` = 1 and no parity flag: push the byte and go to IDLE at once. This gives half a bit of resync margin.
  - `rxs` = 1 and parity flag set: pulse `parity_err`, discard the byte, go to IDLE.
  - `rxs` = 0: pulse `frame_err`, discard the byte, go to BREAK.
- BREAK: wait for `rxs` = 1, then go to IDLE. A held-low line therefore produces exactly one `frame_err`.
- FIFO push when full with no pop in the same cycle: drop the new byte, pulse `overrun`, leave FIFO contents unchanged.
- FIFO push and pop in the same cycle:
  - Allowed when full: net count unchanged, `overrun` = 0.
  - When empty, the pop is ignored and the push lands.
- Pointers are log2(`FIFO_DEPTH`)+1 bits and wrap naturally. Full means the MSBs differ and the rest are equal; empty means the pointers are equal.

## Timing
- Reset values: state IDLE, counter 0, pointers 0, `rx_empty` 1, `rx_full` 0, `rx_data` 0x00, `frame_err`/`overrun`/`parity_err` 0.
- Synchronizer latency: 2 cycles from a pin edge to `rxs`.
- Let cycle 0 be the first cycle with `rxs` = 0 in IDLE.
  - Start sample: cycle `CLKS_PER_BIT/2`.
  - Data bit k sample: `CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT`.
  - Stop sample: `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT`, or `+ 10*CLKS_PER_BIT` with parity.
- `rx_empty` falls, `rx_data` updates and the error pulses fire in the cycle after the stop sample (registered).
- Pop: `rx_data` shows the next entry in the cycle after the `rd_en` edge.
- Reset mid-byte: an immediate asynchronous return to reset values; the partial byte and FIFO contents are lost.

## Configuration
- `UART_RX_PARITY_EN` defined: an even-parity bit is expected between data bit 7 and the stop bit (8E1), and `parity_err` is active.
- Not defined: the frame is 8N1, there is no PARITY state, and `parity_err` is constant 0.

## Test plan
All scenarios use `CLKS_PER_BIT` = 16 and `FIFO_DEPTH` = 4 for simulation speed.
- Send 0xA5 (8N1) → `rx_empty` falls 1 cycle after the stop sample (cycle 152 after the synced start edge), `rx_data` = 0xA5, no error pulses. Then `rd_en` for 1 cycle → `rx_empty` = 1.
- Hold `Rx_Serial` low for 5 cycles, then high → state returns to IDLE, FIFO empty, no pulses.
- Send 0x3C with the stop bit driven 0, hold low for 40 cycles, then high → exactly one `frame_err` pulse, FIFO empty. A following 0x55 is received correctly.
- Send 0x01, 0x02, 0x03, 0x04, 0x05 with no reads → `rx_full` = 1 after 0x04, one `overrun` pulse on 0x05. Four reads return 0x01–0x04, then `rx_empty` = 1.
- Assert `reset` during data bit 3 of 0xF0, release, then send 0x0F → only 0x0F is queued, no error pulses.
- With `UART_RX_PARITY_EN`: send 0x07 with parity bit 1 → byte queued. Send 0x07 with parity bit 0 → one `parity_err` pulse, byte discarded.
